// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: Whack-a-Mole round sequencer.
// Lights a pseudo-random hole for SHOW_TICKS ticks, scores lit-hole hits,
// counts timed-out moles, and runs ROUNDS rounds before holding the result.
// Optional feature macro: MOLE_PENALTY_EN (wrong-hole hits cost one point).
module mole_round_ctrl #(
   parameter int unsigned N_HOLES    = 4,
   parameter int unsigned SHOW_TICKS = 8,
   parameter int unsigned GAP_TICKS  = 4,
   parameter int unsigned ROUNDS     = 16,
   parameter int unsigned SCORE_W    = 8,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_i,
   input  logic               start_i,
   input  logic [N_HOLES-1:0] hit_i,
   output logic [N_HOLES-1:0] mole_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [SCORE_W-1:0] miss_o,
   output logic               busy_o,
   output logic               over_o
);

   localparam int unsigned HW        = $clog2(N_HOLES);
   localparam logic [7:0]  GAP_LD    = 8'(GAP_TICKS);
   localparam logic [7:0]  SHOW_LD   = 8'(SHOW_TICKS);
   localparam logic [7:0]  ROUNDS_LD = 8'(ROUNDS);

   typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

   state_t             state_q, state_d;
   logic [N_HOLES-1:0] mole_q, mole_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] miss_q, miss_d;
   logic               busy_q, busy_d;
   logic               over_q, over_d;
   logic [7:0]         round_q, round_d;
   logic [7:0]         timer_q, timer_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [HW-1:0]      prev_q, prev_d;

   logic [HW-1:0]      cand;
   logic [HW-1:0]      hole;
   logic               hit_lit;
   logic               round_end;

   // LFSR step and hole pick: avoid repeating the previously lit hole
   always_comb begin
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      cand    = lfsr_q[HW-1:0];
      hole    = (cand == prev_q) ? cand + HW'(1) : cand;
      hit_lit = |(hit_i & mole_q);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      mole_d    = mole_q;
      score_d   = score_q;
      miss_d    = miss_q;
      busy_d    = busy_q;
      over_d    = over_q;
      round_d   = round_q;
      timer_d   = timer_q;
      prev_d    = prev_q;
      round_end = 1'b0;

      case (state_q)
         IDLE, OVER: begin
            if (start_i) begin
               score_d = '0;
               miss_d  = '0;
               round_d = '0;
               timer_d = GAP_LD;
               busy_d  = 1'b1;
               over_d  = 1'b0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (tick_i) begin
               if (timer_q == 8'd1) begin
                  mole_d  = {{(N_HOLES-1){1'b0}}, 1'b1} << hole;
                  prev_d  = hole;
                  timer_d = SHOW_LD;
                  state_d = SHOW;
               end else begin
                  timer_d = timer_q - 8'd1;
               end
            end
         end
         SHOW: begin
            if (hit_lit) begin
               // A lit-hole hit outranks a same-cycle timeout tick
               score_d   = (score_q == '1) ? score_q : score_q + 1'b1;
               mole_d    = '0;
               round_end = 1'b1;
            end else begin
               if (tick_i) begin
                  if (timer_q == 8'd1) begin
                     miss_d    = (miss_q == '1) ? miss_q : miss_q + 1'b1;
                     mole_d    = '0;
                     round_end = 1'b1;
                  end else begin
                     timer_d = timer_q - 8'd1;
                  end
               end
`ifdef MOLE_PENALTY_EN
               if (|(hit_i & ~mole_q) && (score_q != '0)) begin
                  score_d = score_q - 1'b1;
               end
`else
               // Wrong-hole hits carry no consequence
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (round_end) begin
         round_d = round_q + 8'd1;
         if (round_q + 8'd1 == ROUNDS_LD) begin
            state_d = OVER;
            busy_d  = 1'b0;
            over_d  = 1'b1;
         end else begin
            state_d = GAP;
            timer_d = GAP_LD;
         end
      end
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mole_q  <= '0;
         score_q <= '0;
         miss_q  <= '0;
         busy_q  <= 1'b0;
         over_q  <= 1'b0;
         round_q <= '0;
         timer_q <= '0;
         lfsr_q  <= LFSR_SEED;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         mole_q  <= mole_d;
         score_q <= score_d;
         miss_q  <= miss_d;
         busy_q  <= busy_d;
         over_q  <= over_d;
         round_q <= round_d;
         timer_q <= timer_d;
         lfsr_q  <= lfsr_d;
         prev_q  <= prev_d;
      end
   end

   assign mole_o  = mole_q;
   assign score_o = score_q;
   assign miss_o  = miss_q;
   assign busy_o  = busy_q;
   assign over_o  = over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl (default parameters).
module tb_mole_round_ctrl;

   localparam int unsigned NH     = 4;
   localparam int unsigned GAPT   = 4;
   localparam int unsigned SHOWT  = 8;
   localparam int unsigned NROUND = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          start = 1'b0;
   logic [NH-1:0] hit = '0;
   logic [NH-1:0] mole;
   logic [7:0]    score;
   logic [7:0]    miss;
   logic          busy;
   logic          over;

   mole_round_ctrl #(
      .N_HOLES(NH), .SHOW_TICKS(SHOWT), .GAP_TICKS(GAPT), .ROUNDS(NROUND),
      .SCORE_W(8), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_i(tick), .start_i(start), .hit_i(hit),
      .mole_o(mole), .score_o(score), .miss_o(miss), .busy_o(busy), .over_o(over)
   );

   always #5 clk = ~clk;

   // Reference LFSR (x^8+x^6+x^5+x^4+1); m_last holds the value seen before the latest edge
   logic [7:0] m_lfsr, m_last;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 8'hA5;
         m_last <= 8'hA5;
      end else begin
         m_last <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   int unsigned   n_pass = 0;
   int unsigned   n_total = 0;
   logic [NH-1:0] last_mole = '0;
   logic [NH-1:0] last_lit = '0;
   logic [1:0]    m_prev = '0;

   typedef struct {
      bit t, s, hl, hw;
      int sc, ms;
      bit bz, ov, lit;
   } vec_t;

   typedef struct {
      int sc, ms;
      bit bz, ov, lit;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Called after every edge: when a mole appears, compare with the reference pick
   task automatic hole_mon();
      logic [1:0]    c;
      logic [NH-1:0] onehot;
      if (mole != '0 && last_mole == '0) begin
         c = m_last[1:0];
         if (c == m_prev) c = c + 2'd1;
         onehot = 4'b0001 << c;
         check("hole_pick", 32'(mole), 32'(onehot));
         check("no_repeat", 32'(mole == last_lit), 32'd0);
         m_prev   = c;
         last_lit = mole;
      end
      last_mole = mole;
   endtask

   // One clock cycle of stimulus; hl hits the lit hole, hw hits every unlit hole
   task automatic step(input bit t, input bit s, input bit hl, input bit hw);
      logic [NH-1:0] hv;
      hv = '0;
      if (hl) hv = hv | mole;
      if (hw) hv = hv | ~mole;
      tick = t; start = s; hit = hv;
      @(posedge clk);
      #1;
      tick = 1'b0; start = 1'b0; hit = '0;
      hole_mon();
   endtask

   task automatic add(input bit t, input bit s, input bit hl, input bit hw,
                      input int sc, input int ms, input bit bz, input bit ov, input bit lit);
      vec_t v;
      v.t = t; v.s = s; v.hl = hl; v.hw = hw;
      v.sc = sc; v.ms = ms; v.bz = bz; v.ov = ov; v.lit = lit;
      tbl.push_back(v);
   endtask

   task automatic play_hit_round();
      for (int i = 0; i < int'(GAPT); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      int pen_sc;
`ifdef MOLE_PENALTY_EN
      pen_sc = 1;
`else
      pen_sc = 2;
`endif
      // Vector table, starting from IDLE after reset
      add(1,0,0,0, 0,0,0,0,0);                      // tick in IDLE ignored
      add(0,0,0,1, 0,0,0,0,0);                      // hits in IDLE ignored
      add(1,1,0,0, 0,0,1,0,0);                      // start+tick: start taken, tick dropped
      add(0,1,0,0, 0,0,1,0,0);                      // start in GAP ignored
      add(1,0,0,0, 0,0,1,0,0);
      add(1,0,0,0, 0,0,1,0,0);
      add(0,0,0,1, 0,0,1,0,0);                      // hits in GAP ignored
      add(1,0,0,0, 0,0,1,0,0);
      add(1,0,0,0, 0,0,1,0,1);                      // 4th counted tick lights a mole
      add(0,0,1,0, 1,0,1,0,0);                      // lit hit scores, mole off
      for (int i = 0; i < 3; i++) add(1,0,0,0, 1,0,1,0,0);
      add(1,0,0,0, 1,0,1,0,1);
      for (int i = 0; i < 7; i++) add(1,0,0,0, 1,0,1,0,1);
      add(1,0,0,0, 1,1,1,0,0);                      // 8th tick: miss
      for (int i = 0; i < 3; i++) add(1,0,0,0, 1,1,1,0,0);
      add(1,0,0,0, 1,1,1,0,1);
      for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1,1,0,1);
      add(1,0,1,0, 2,1,1,0,0);                      // hit with the timeout tick: hit wins
      for (int i = 0; i < 3; i++) add(1,0,0,0, 2,1,1,0,0);
      add(1,0,0,0, 2,1,1,0,1);
      add(0,0,0,1, pen_sc,1,1,0,1);                 // wrong-hole hit
      add(1,1,0,0, pen_sc,1,1,0,1);                 // start in SHOW ignored
      add(0,0,1,1, pen_sc+1,1,1,0,0);               // all bits: lit bit decides

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mole",  32'(mole),  32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_miss",  32'(miss),  32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_over",  32'(over),  32'd0);
      #2 rst_n = 1'b1;

      foreach (tbl[i]) begin
         exp_t e;
         exp_t got;
         e.sc = tbl[i].sc; e.ms = tbl[i].ms; e.bz = tbl[i].bz; e.ov = tbl[i].ov; e.lit = tbl[i].lit;
         sb.push_back(e);
         step(tbl[i].t, tbl[i].s, tbl[i].hl, tbl[i].hw);
         got = sb.pop_front();
         check($sformatf("v%0d_score", i), 32'(score), 32'(got.sc));
         check($sformatf("v%0d_miss", i),  32'(miss),  32'(got.ms));
         check($sformatf("v%0d_busy", i),  32'(busy),  32'(got.bz));
         check($sformatf("v%0d_over", i),  32'(over),  32'(got.ov));
         check($sformatf("v%0d_lit", i),   32'(mole != '0), 32'(got.lit));
      end

      // Finish this game: 12 more hit rounds
      for (int r = 0; r < int'(NROUND) - 4; r++) play_hit_round();
      check("g1_over",  32'(over),  32'd1);
      check("g1_busy",  32'(busy),  32'd0);
      check("g1_score", 32'(score), 32'(pen_sc + 1 + 12));
      check("g1_miss",  32'(miss),  32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("over_hold", 32'(over), 32'd1);

      // Restart from OVER, then a full all-hit game
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("rs_score", 32'(score), 32'd0);
      check("rs_miss",  32'(miss),  32'd0);
      check("rs_busy",  32'(busy),  32'd1);
      check("rs_over",  32'(over),  32'd0);
      for (int r = 0; r < int'(NROUND) - 1; r++) play_hit_round();
      check("r15_busy", 32'(busy), 32'd1);
      check("r15_over", 32'(over), 32'd0);
      play_hit_round();
      check("g2_over",  32'(over),  32'd1);
      check("g2_busy",  32'(busy),  32'd0);
      check("g2_score", 32'(score), 32'd16);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("g3_score", 32'(score), 32'd0);
      check("g3_busy",  32'(busy),  32'd1);

      // One scored round, then reset while a mole is lit
      play_hit_round();
      for (int i = 0; i < int'(GAPT); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("pre_rst_lit",   32'(mole != '0), 32'd1);
      check("pre_rst_score", 32'(score), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mole",  32'(mole),  32'd0);
      check("arst_score", 32'(score), 32'd0);
      check("arst_busy",  32'(busy),  32'd0);
      check("arst_over",  32'(over),  32'd0);
      m_prev = '0; last_mole = '0; last_lit = '0;
      #2 rst_n = 1'b1;

      // Fresh game after reset: first hole follows the reseeded LFSR
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < int'(GAPT); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("post_rst_lit", 32'(mole != '0), 32'd1);
      for (int i = 0; i < int'(SHOWT); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("post_rst_miss", 32'(miss), 32'd1);
      check("post_rst_mole", 32'(mole), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
